pll_clk_sel_ctrl: RTL and testbench
===================================

// Module: pll_clk_sel_ctrl
// PURPOSE
//   Control stage directly upstream of the PLL/BUFGMUX clock-selection wrapper; runs on the 100 MHz board clock.
//   Debounces push-button and slide-switch inputs and drives the PLL reset and the 2-bit clock-mux select.
//   Sequences PLL reset, waits for a stable lock, and only then applies the user clock selection.
//   Counts lock-loss events and flags "selected clock valid" for downstream/scope debug.
// PARAMETERS
//   DEBOUNCE_CYCLES     1000000  consecutive stable samples needed to accept a button/switch change (10 ms @ 100 MHz)
//   RST_PULSE_CYCLES    100      pll_rst high time in clk cycles after reset release or button press
//   LOCK_WAIT_CYCLES    1000     consecutive synchronized-locked cycles required before entering RUN
//   SWITCH_HOLD_CYCLES  16       ready low time after a select change
//   LOSS_CNT_WIDTH      8        width of lock-loss counter
// PORTS
//   clk          in   1               100 MHz on-board clock
//   rst_n        in   1               asynchronous active-low reset
//   btn_raw      in   1               raw push-button (PLL re-reset request), asynchronous, bouncy
//   sw_raw       in   2               raw slide switches (requested clock select), asynchronous, bouncy
//   pll_locked   in   1               PLL locked, asynchronous to clk
//   pll_rst      out  1               PLL reset, active-high
//   sel          out  2               clock-mux select driven to the PLL wrapper
//   ready        out  1               1 = PLL locked and sel stable
//   loss_count   out  LOSS_CNT_WIDTH  number of lock losses seen in RUN/SWITCH, saturating
// BEHAVIOUR
//   Reset (rst_n=0): pll_rst=1, sel=2'b00, ready=0, loss_count=0, state=RST_PULSE, all counters/debounced values 0.
//   Sync: btn_raw, sw_raw[1:0] and pll_locked each pass through a 2-FF synchronizer (2-cycle latency).
//   Debounce (per bit): counter clears whenever synced != debounced value.
//     Debounced value takes the synced value after DEBOUNCE_CYCLES consecutive differing cycles.
//     Any bounce restarts the count. btn_press = 1-cycle pulse on debounced btn 0->1.
//   Counters sized $clog2(max count + 1); they clear on every state entry.
//   FSM states and transitions:
//     RST_PULSE: pll_rst=1, ready=0. Go to WAIT_LOCK after exactly RST_PULSE_CYCLES cycles.
//       btn_press here is ignored.
//     WAIT_LOCK: pll_rst=0, ready=0. When locked_sync=1, go to SETTLE.
//     SETTLE: ready=0. If locked_sync=0, go to WAIT_LOCK (no loss counted).
//       After LOCK_WAIT_CYCLES consecutive locked cycles, go to RUN.
//       On that same edge, sel <= sw_db.
//     RUN: ready=1. Priority order:
//       (1) locked_sync=0: loss_count+1 (saturate at all-ones), ready<=0, go to WAIT_LOCK.
//       (2) btn_press: go to RST_PULSE.
//       (3) sw_db != sel: sel <= sw_db, ready<=0, go to SWITCH.
//     SWITCH: ready=0 for SWITCH_HOLD_CYCLES cycles, then go to RUN.
//       Lock loss counts and exits as in RUN.
//       btn_press goes to RST_PULSE.
//       A further sw_db change updates sel and restarts the hold count.
//   btn_press in WAIT_LOCK or SETTLE goes to RST_PULSE.
//   sel changes only on entry to RUN from SETTLE or on a RUN/SWITCH switch change; it never changes while pll_rst=1.
//   All outputs are registered. Lock-loss latency: 2 sync cycles + 1 (ready falls 3 clks after pll_locked falls).
//   rst_n asserted mid-operation: immediate async return to reset values; loss_count is cleared.
// TESTING  (bench params: DEBOUNCE=4, RST_PULSE=3, LOCK_WAIT=5, SWITCH_HOLD=2, LOSS_CNT_WIDTH=2)
//   1. Release rst_n -> pll_rst=1 for exactly 3 clks, then 0.
//      Raise pll_locked -> ready=1 exactly 2+5+1 clks later; sel=sw_db=00.
//   2. sw_raw 00->10 held stable in RUN -> sel=10 at 2+4+1 clks; ready low 2 clks, then high.
//      Toggle sw every 3 clks -> sel unchanged.
//   3. Drop pll_locked in RUN -> ready=0 3 clks later; loss_count 0->1; FSM returns to WAIT_LOCK.
//      Repeat 4 times -> loss_count saturates at 3.
//   4. Drop pll_locked for 2 clks during SETTLE -> ready stays 0; settle restarts; loss_count unchanged.
//   5. Button held 6 clks in RUN -> one RST_PULSE: pll_rst=1 for 3 clks, ready=0.
//      A second press during RST_PULSE is ignored (no extended pulse).
//   6. Assert rst_n low in SWITCH with loss_count=2 -> immediately pll_rst=1, sel=00, ready=0, loss_count=0.

Source files
------------

// File: rtl/pll_clk_sel_ctrl.sv
// PLL reset sequencing and clock-mux select control with debounced button/switch inputs.
// The mux select is only applied once the PLL has held lock for a full settle window.
module pll_clk_sel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES    = 1000000,
  parameter int unsigned RST_PULSE_CYCLES   = 100,
  parameter int unsigned LOCK_WAIT_CYCLES   = 1000,
  parameter int unsigned SWITCH_HOLD_CYCLES = 16,
  parameter int unsigned LOSS_CNT_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_raw,
  input  logic [1:0]                sw_raw,
  input  logic                      pll_locked,
  output logic                      pll_rst,
  output logic [1:0]                sel,
  output logic                      ready,
  output logic [LOSS_CNT_WIDTH-1:0] loss_count
);

  localparam int unsigned NDB     = 3;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MAX_A   = (RST_PULSE_CYCLES > LOCK_WAIT_CYCLES) ? RST_PULSE_CYCLES
                                                                          : LOCK_WAIT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > SWITCH_HOLD_CYCLES) ? MAX_A : SWITCH_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_RST_PULSE = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RUN       = 3'd3,
    S_SWITCH    = 3'd4
  } state_t;

  // Two-flop synchronizers; bit 3 = pll_locked, bits 2:1 = sw, bit 0 = btn.
  logic [3:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {pll_locked, sw_raw, btn_raw};
      sync2 <= sync1;
    end
  end

  logic locked_sync;
  assign locked_sync = sync2[3];

  // Per-bit debounce: a value is accepted only after an unbroken run of differing samples.
  logic [NDB-1:0]  db;
  logic [DB_W-1:0] db_cnt [NDB];
  logic            btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db    <= '0;
      btn_q <= 1'b0;
      for (int i = 0; i < NDB; i++) db_cnt[i] <= '0;
    end else begin
      btn_q <= db[0];
      for (int i = 0; i < NDB; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic       btn_press_c;
  logic [1:0] sw_db;
  assign btn_press_c = db[0] & ~btn_q;
  assign sw_db       = db[2:1];

  state_t                    state, state_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic [1:0]                sel_d;
  logic [LOSS_CNT_WIDTH-1:0] loss_d;
  logic                      restart;

  always_comb begin
    state_d = state;
    cnt_d   = '0;
    sel_d   = sel;
    loss_d  = loss_count;
    restart = 1'b0;
    case (state)
      S_RST_PULSE: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (btn_press_c)      state_d = S_RST_PULSE;
        else if (locked_sync) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt + CNT_W'(1);
        if (!locked_sync)     state_d = S_WAIT_LOCK;
        else if (btn_press_c) state_d = S_RST_PULSE;
        else if (cnt == CNT_W'(LOCK_WAIT_CYCLES - 1)) begin
          state_d = S_RUN;
          sel_d   = sw_db;
        end
      end
      S_RUN, S_SWITCH: begin
        cnt_d = cnt + CNT_W'(1);
        if (!locked_sync) begin
          if (loss_count != {LOSS_CNT_WIDTH{1'b1}}) loss_d = loss_count + LOSS_CNT_WIDTH'(1);
          state_d = S_WAIT_LOCK;
        end else if (btn_press_c) begin
          state_d = S_RST_PULSE;
        end else if (sw_db != sel) begin
          sel_d   = sw_db;
          state_d = S_SWITCH;
          restart = 1'b1;
        end else if (state == S_SWITCH && cnt == CNT_W'(SWITCH_HOLD_CYCLES - 1)) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RST_PULSE;
    endcase
    // Every state entry (including a switch re-entry) starts its timer from zero.
    if (state_d != state || restart) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RST_PULSE;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      sel        <= 2'b00;
      ready      <= 1'b0;
      loss_count <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sel        <= sel_d;
      loss_count <= loss_d;
      pll_rst    <= (state_d == S_RST_PULSE);
      ready      <= (state_d == S_RUN);
    end
  end

endmodule

// File: tb/tb_pll_clk_sel_ctrl.sv
// Bench for pll_clk_sel_ctrl: directed latency checks plus random stimulus against a
// timestamp-based reference model of the sequencing rules.
module tb_pll_clk_sel_ctrl;

  localparam int unsigned DEB   = 4;
  localparam int unsigned RSTP  = 3;
  localparam int unsigned LOCKW = 5;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned LW    = 2;
  localparam int          LOSS_MAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          btn_raw = 1'b0;
  logic [1:0]    sw_raw = 2'b00;
  logic          pll_locked = 1'b0;
  logic          pll_rst;
  logic [1:0]    sel;
  logic          ready;
  logic [LW-1:0] loss_count;

  int vectors = 0;
  int miscompares = 0;

  pll_clk_sel_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .RST_PULSE_CYCLES(RSTP), .LOCK_WAIT_CYCLES(LOCKW),
    .SWITCH_HOLD_CYCLES(HOLD), .LOSS_CNT_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sel(sel), .ready(ready), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  // Reference model: edges are numbered from reset release; each phase remembers the edge it began on.
  typedef enum int {P_RSTP, P_WAIT, P_SETTLE, P_RUN, P_SWITCH} phase_t;
  phase_t     m_phase;
  int         m_edge;
  int         m_enter;
  logic [3:0] m_raw[$];
  logic [2:0] m_db;
  logic       m_btn_old;
  logic [1:0] m_sel;
  int         m_loss;

  function automatic void m_reset();
    m_phase = P_RSTP; m_edge = 0; m_enter = 0; m_raw.delete();
    m_db = 3'b000; m_btn_old = 1'b0; m_sel = 2'b00; m_loss = 0;
  endfunction

  // Raw value presented at edge k is seen by the logic two edges later.
  function automatic logic [3:0] synced(int k);
    if (k < 3) return 4'b0000;
    return m_raw[k-3];
  endfunction

  function automatic void go(phase_t p);
    m_phase = p;
    m_enter = m_edge;
  endfunction

  function automatic void m_step();
    logic [3:0] s, sv;
    logic       lk, press, all_diff;
    logic [1:0] swdb;
    m_edge++;
    m_raw.push_back({pll_locked, sw_raw, btn_raw});
    s     = synced(m_edge);
    lk    = s[3];
    press = m_db[0] & ~m_btn_old;
    swdb  = m_db[2:1];
    case (m_phase)
      P_RSTP:   if (m_edge - m_enter == RSTP) go(P_WAIT);
      P_WAIT:   if (press) go(P_RSTP); else if (lk) go(P_SETTLE);
      P_SETTLE: begin
        if (!lk) go(P_WAIT);
        else if (press) go(P_RSTP);
        else if (m_edge - m_enter == LOCKW) begin m_sel = swdb; go(P_RUN); end
      end
      default: begin
        if (!lk) begin
          if (m_loss < LOSS_MAX) m_loss++;
          go(P_WAIT);
        end else if (press) go(P_RSTP);
        else if (swdb != m_sel) begin m_sel = swdb; go(P_SWITCH); end
        else if (m_phase == P_SWITCH && m_edge - m_enter == HOLD) go(P_RUN);
      end
    endcase
    m_btn_old = m_db[0];
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        sv = synced(m_edge - j);
        if (sv[b] == m_db[b]) all_diff = 1'b0;
      end
      if (all_diff) m_db[b] = ~m_db[b];
    end
  endfunction

  function automatic logic [5:0] exp_outs();
    return {m_phase == P_RSTP, m_sel, m_phase == P_RUN, LW'(m_loss)};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    m_reset();
    #2;
    vectors++;
    if ({pll_rst, sel, ready, loss_count} !== 6'b1_00_0_00) begin
      miscompares++;
      $display("FAIL reset_values: got %b want 100000", {pll_rst, sel, ready, loss_count});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (pll_rst !== 1'b1) begin
      miscompares++; $display("FAIL rst_pulse_start: pll_rst=%b want 1", pll_rst);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (pll_rst !== (i < 3)) begin
        miscompares++; $display("FAIL rst_pulse_len: edge %0d pll_rst=%b want %b", i, pll_rst, i < 3);
      end
    end
  endtask

  task automatic test_lock_up();
    int n;
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 30) begin tick(); n++; end
    vectors++;
    if (n != 8) begin miscompares++; $display("FAIL lock_to_ready: got %0d clks want 8", n); end
    vectors++;
    if (sel !== 2'b00) begin miscompares++; $display("FAIL initial_sel: got %b want 00", sel); end
    vectors++;
    if ({pll_rst, sel, ready, loss_count} !== exp_outs()) begin
      miscompares++; $display("FAIL lock_up_model: dut %b model %b", {pll_rst, sel, ready, loss_count}, exp_outs());
    end
  endtask

  task automatic test_switch();
    int n;
    sw_raw = 2'b10;
    n = 0;
    while (sel !== 2'b10 && n < 30) begin tick(); n++; end
    vectors++;
    if (n != 7) begin miscompares++; $display("FAIL switch_latency: got %0d clks want 7", n); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ready !== (i == 2)) begin
        miscompares++; $display("FAIL switch_hold: step %0d ready=%b want %b", i, ready, i == 2);
      end
      if (i < 2) tick();
    end
    for (int i = 0; i < 33; i++) begin
      if (i % 3 == 0 && i < 30) sw_raw ^= 2'b01;
      tick();
      vectors++;
      if (sel !== 2'b10 || {pll_rst, sel, ready, loss_count} !== exp_outs()) begin
        miscompares++;
        $display("FAIL bounce_reject: i=%0d dut %b model %b", i, {pll_rst, sel, ready, loss_count}, exp_outs());
      end
    end
  endtask

  task automatic test_settle_glitch();
    int n;
    pll_locked = 1'b0;
    repeat (3) tick();
    vectors++;
    if (ready !== 1'b0 || loss_count !== 2'd1) begin
      miscompares++; $display("FAIL first_loss: ready=%b loss=%0d want 0/1", ready, loss_count);
    end
    pll_locked = 1'b1;
    repeat (4) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 30) begin tick(); n++; end
    vectors++;
    if (n != 8 || loss_count !== 2'd1) begin
      miscompares++; $display("FAIL settle_restart: ready after %0d clks loss=%0d want 8/1", n, loss_count);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    int want;
    for (int i = 0; i < 4; i++) begin
      want = (i + 2 > LOSS_MAX) ? LOSS_MAX : i + 2;
      pll_locked = 1'b0;
      n = 0;
      while (ready !== 1'b0 && n < 10) begin tick(); n++; end
      vectors++;
      if (n != 3 || loss_count !== LW'(want)) begin
        miscompares++; $display("FAIL lock_loss: drop %0d latency %0d loss=%0d want 3/%0d", i, n, loss_count, want);
      end
      pll_locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 30) begin tick(); n++; end
      vectors++;
      if (n != 8) begin miscompares++; $display("FAIL relock: drop %0d got %0d clks want 8", i, n); end
    end
  endtask

  task automatic test_button();
    int n;
    btn_raw = 1'b1;
    n = 0;
    while (pll_rst !== 1'b1 && n < 30) begin
      tick(); n++;
      if (n == 6) btn_raw = 1'b0;
    end
    vectors++;
    if (n != 7 || ready !== 1'b0) begin
      miscompares++; $display("FAIL btn_latency: pll_rst after %0d clks ready=%b want 7/0", n, ready);
    end
    n = 0;
    while (pll_rst === 1'b1 && n < 30) begin tick(); n++; end
    vectors++;
    if (n != 3) begin miscompares++; $display("FAIL btn_pulse_len: got %0d clks want 3", n); end
    btn_raw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 5) btn_raw = 1'b0;
      vectors++;
      if ({pll_rst, sel, ready, loss_count} !== exp_outs()) begin
        miscompares++; $display("FAIL btn_repress: i=%0d dut %b model %b", i, {pll_rst, sel, ready, loss_count}, exp_outs());
      end
    end
    n = 0;
    while (ready !== 1'b1 && n < 40) begin tick(); n++; end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL btn_recover: ready=%b want 1", ready); end
  endtask

  task automatic test_reset_mid();
    int n;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin tick(); n++; end
    for (int i = 0; i < 2; i++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      pll_locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 30) begin tick(); n++; end
    end
    vectors++;
    if (loss_count !== 2'd2 || sel !== 2'b10) begin
      miscompares++; $display("FAIL pre_reset_state: loss=%0d sel=%b want 2/10", loss_count, sel);
    end
    sw_raw = 2'b01;
    n = 0;
    while (sel !== 2'b01 && n < 20) begin tick(); n++; end
    vectors++;
    if (sel !== 2'b01 || ready !== 1'b0) begin
      miscompares++; $display("FAIL enter_switch: sel=%b ready=%b want 01/0", sel, ready);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pll_rst, sel, ready, loss_count} !== 6'b1_00_0_00) begin
      miscompares++; $display("FAIL async_reset: got %b want 100000", {pll_rst, sel, ready, loss_count});
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (pll_locked) begin
        if ($urandom_range(0, 99) < 2) pll_locked = 1'b0;
      end else if ($urandom_range(0, 99) < 30) pll_locked = 1'b1;
      if ($urandom_range(0, 99) < 4) sw_raw = 2'($urandom_range(0, 3));
      if (btn_raw) begin
        if ($urandom_range(0, 99) < 20) btn_raw = 1'b0;
      end else if ($urandom_range(0, 199) < 3) btn_raw = 1'b1;
      tick();
      vectors++;
      if ({pll_rst, sel, ready, loss_count} !== exp_outs()) begin
        miscompares++; $display("FAIL random: i=%0d dut %b model %b", i, {pll_rst, sel, ready, loss_count}, exp_outs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_switch();
    test_settle_glitch();
    test_lock_loss();
    test_button();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
